// File: rtl/vga_fb_fetch_ctrl.sv
// Frame-buffer fetch controller: on each line request it bursts one display
// line out of the single-port pixel RAM into the line buffer, and shares the
// same RAM port with an image-loader writer. In FETCH the writer is offered one
// slot in every WR_SLOT cycles so it cannot be starved for a whole line.
//
// Handshakes:
//   line_req : one-cycle pulse; line_y is valid in the same cycle. Accepted only
//              in IDLE with line_y < V_ACT, otherwise req_err pulses.
//   wr_req   : level, held with wr_addr/wr_data until wr_ack. wr_ack pulses in
//              the cycle the write is presented to the RAM. No write is issued
//              while wr_ack is high, so the writer may update or drop its request
//              on the edge that ends the ack cycle.
//   mem_rdata: sampled at the edge that ends the cycle in which a read is
//              presented on mem_*; it lands on lb_* in the following cycle.
module vga_fb_fetch_ctrl #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int WR_SLOT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [11:0]       line_y,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              busy,
    output logic              line_done,
    output logic              req_err
);

    localparam int                SLOT_W    = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'((WR_SLOT > 0) ? WR_SLOT - 1 : 0);
    localparam logic [9:0]        X_LAST    = 10'(H_ACT - 1);
    localparam logic [31:0]       FB_PIX    = 32'(H_ACT * V_ACT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // FSM and fetch bookkeeping
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [9:0]          x_q, x_d;        // next pixel to read
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [9:0]          rd_x_q, rd_x_d;  // pixel x of the read currently on mem_*

    // Registered outputs
    logic                wr_ack_q, wr_ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                lb_we_q, lb_we_d;
    logic [9:0]          lb_addr_q, lb_addr_d;
    logic [DATA_W-1:0]   lb_wdata_q, lb_wdata_d;
    logic                busy_q, busy_d;
    logic                line_done_q, line_done_d;
    logic                req_err_q, req_err_d;

    // Per-cycle decisions
    logic                line_ok;
    logic [ADDR_W-1:0]   line_base;
    logic                wr_in_fb;
    logic                slot_hit;
    logic                rd_issue;
    logic                wr_issue;
    logic [ADDR_W-1:0]   rd_addr;

    // Request qualification: line range, line base address, writer address range
    always_comb begin
        line_ok   = (32'(line_y) < 32'(V_ACT));
        line_base = ADDR_W'(32'(line_y) * 32'(H_ACT));
        wr_in_fb  = (32'(wr_addr) < FB_PIX);
        slot_hit  = (WR_SLOT > 0) && (slot_q == SLOT_LAST) && wr_req && !wr_ack_q;
    end

    // Next-state logic: decides each cycle whether a read, a write or nothing is issued
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        x_d       = x_q;
        slot_d    = slot_q;
        rd_x_d    = rd_x_q;
        rd_issue  = 1'b0;
        wr_issue  = 1'b0;
        rd_addr   = '0;
        req_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A line request wins over a pending writer in the same cycle.
                if (line_req) begin
                    if (line_ok) begin
                        base_d   = line_base;
                        rd_issue = 1'b1;
                        rd_addr  = line_base;
                        rd_x_d   = 10'd0;
                        x_d      = 10'd1;
                        slot_d   = '0;
                        state_d  = FETCH;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end else if (wr_req && !wr_ack_q) begin
                    wr_issue = 1'b1;
                end
            end

            FETCH: begin
                req_err_d = line_req;
                if (WR_SLOT > 0) begin
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
                end
                if (slot_hit) begin
                    // Writer slot: the read pointer holds, the line just ends a cycle later.
                    wr_issue = 1'b1;
                end else begin
                    rd_issue = 1'b1;
                    rd_addr  = base_q + ADDR_W'(x_q);
                    rd_x_d   = x_q;
                    x_d      = x_q + 10'd1;
                    if (x_q == X_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // The last read is on mem_* this cycle; its data is captured below.
                req_err_d = line_req;
                x_d       = 10'd0;
                slot_d    = '0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port and writer acknowledge for the next cycle
    always_comb begin
        wr_ack_d    = wr_issue;
        mem_we_d    = wr_issue && wr_in_fb;
        mem_en_d    = rd_issue || mem_we_d;
        mem_addr_d  = rd_issue ? rd_addr : (mem_we_d ? wr_addr : '0);
        mem_wdata_d = mem_we_d ? wr_data : '0;
        busy_d      = (state_q != IDLE) || (state_d != IDLE);
    end

    // Read return: the read presented this cycle is written to the line buffer next cycle
    always_comb begin
        lb_we_d     = mem_en_q && !mem_we_q;
        lb_addr_d   = lb_we_d ? rd_x_q : 10'd0;
        lb_wdata_d  = lb_we_d ? mem_rdata : '0;
        line_done_d = lb_we_d && (rd_x_q == X_LAST);
    end

    // State and output registers; reset aborts any line in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            x_q         <= '0;
            slot_q      <= '0;
            rd_x_q      <= '0;
            wr_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_wdata_q  <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            x_q         <= x_d;
            slot_q      <= slot_d;
            rd_x_q      <= rd_x_d;
            wr_ack_q    <= wr_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            lb_wdata_q  <= lb_wdata_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            req_err_q   <= req_err_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign lb_we     = lb_we_q;
    assign lb_addr   = lb_addr_q;
    assign lb_wdata  = lb_wdata_q;
    assign busy      = busy_q;
    assign line_done = line_done_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// Bench for vga_fb_fetch_ctrl: one instance with WR_SLOT=8 (sel=0) and one
// with WR_SLOT=0 (sel=1) share the stimulus; sel routes requests and outputs.
module tb_vga_fb_fetch_ctrl;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic              sel;
  logic              line_req;
  logic [11:0]       line_y;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              line_req_a, line_req_b, wr_req_a, wr_req_b;
  assign line_req_a = line_req & ~sel;
  assign line_req_b = line_req & sel;
  assign wr_req_a   = wr_req & ~sel;
  assign wr_req_b   = wr_req & sel;

  // ---------------- per-instance outputs ----------------
  logic              wr_ack_a, mem_en_a, mem_we_a, lb_we_a, busy_a, line_done_a, req_err_a;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_wdata_a, mem_rdata_a, lb_wdata_a;
  logic [9:0]        lb_addr_a;
  logic              wr_ack_b, mem_en_b, mem_we_b, lb_we_b, busy_b, line_done_b, req_err_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_wdata_b, mem_rdata_b, lb_wdata_b;
  logic [9:0]        lb_addr_b;

  // Pixel content of the modelled frame buffer: unique per address
  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    return {a[4:0], a} ^ 24'h3C5A96;
  endfunction

  // RAM model: read data is valid while the read is presented on mem_*
  always_comb begin
    mem_rdata_a = (mem_en_a && !mem_we_a) ? pix(mem_addr_a) : '0;
    mem_rdata_b = (mem_en_b && !mem_we_b) ? pix(mem_addr_b) : '0;
  end

  vga_fb_fetch_ctrl #(.WR_SLOT(8)) u_dut (
    .clk(clk), .rst(rst), .line_req(line_req_a), .line_y(line_y),
    .wr_req(wr_req_a), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .lb_we(lb_we_a), .lb_addr(lb_addr_a), .lb_wdata(lb_wdata_a),
    .busy(busy_a), .line_done(line_done_a), .req_err(req_err_a)
  );

  vga_fb_fetch_ctrl #(.WR_SLOT(0)) u_dut0 (
    .clk(clk), .rst(rst), .line_req(line_req_b), .line_y(line_y),
    .wr_req(wr_req_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .lb_we(lb_we_b), .lb_addr(lb_addr_b), .lb_wdata(lb_wdata_b),
    .busy(busy_b), .line_done(line_done_b), .req_err(req_err_b)
  );

  // Selected instance view
  logic              c_wr_ack, c_mem_en, c_mem_we, c_lb_we, c_busy, c_line_done, c_req_err;
  logic [ADDR_W-1:0] c_mem_addr;
  logic [DATA_W-1:0] c_mem_wdata, c_lb_wdata;
  logic [9:0]        c_lb_addr;
  always_comb begin
    c_wr_ack    = sel ? wr_ack_b    : wr_ack_a;
    c_mem_en    = sel ? mem_en_b    : mem_en_a;
    c_mem_we    = sel ? mem_we_b    : mem_we_a;
    c_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
    c_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
    c_lb_we     = sel ? lb_we_b     : lb_we_a;
    c_lb_addr   = sel ? lb_addr_b   : lb_addr_a;
    c_lb_wdata  = sel ? lb_wdata_b  : lb_wdata_a;
    c_busy      = sel ? busy_b      : busy_a;
    c_line_done = sel ? line_done_b : line_done_a;
    c_req_err   = sel ? req_err_b   : req_err_a;
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line fetch scenarios with hand-computed expectations
  typedef struct {
    logic              sel;        // 0: WR_SLOT=8, 1: WR_SLOT=0
    logic [11:0]       y;
    logic              hold_wr;    // writer requests throughout
    int                intr_cyc;   // cycle of an extra line_req during the fetch (0 = none)
    logic              exp_err;    // request itself is rejected
    logic [ADDR_W-1:0] exp_base;
    int                exp_done;   // cycle carrying line_done
    int                exp_writes; // writes served up to exp_done
    int                exp_ack;    // first wr_ack cycle after exp_done (-1 = none)
  } row_t;

  row_t rows[7];

  task automatic run_row(input int idx, input row_t r);
    int n_cyc, n_rd, n_lb, writes, done_cyc, done_cnt, err_cnt, err_cyc, ack_after;
    logic [ADDR_W-1:0] exp_rd, prev_addr;
    logic prev_rd;
    string pfx;
    pfx = $sformatf("row%0d", idx);
    sel      = r.sel;
    line_y   = r.y;
    line_req = 1'b1;
    wr_req   = r.hold_wr;
    wr_addr  = 19'd1000;
    wr_data  = 24'h100000;
    n_cyc    = r.exp_err ? 6 : r.exp_done + 4;
    exp_rd   = r.exp_base;
    n_rd = 0; n_lb = 0; writes = 0; done_cyc = -1; done_cnt = 0;
    err_cnt = 0; err_cyc = -1; ack_after = -1; prev_rd = 1'b0; prev_addr = '0;
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      line_req = (r.intr_cyc != 0) && (c == r.intr_cyc);
      // reads come out in address order with zero write data
      if (c_mem_en && !c_mem_we) begin
        check({pfx, " rd_addr"}, c_mem_addr, exp_rd);
        check({pfx, " rd_wdata"}, c_mem_wdata, 0);
        exp_rd++;
        n_rd++;
      end
      check({pfx, " wr_ack_vs_we"}, c_wr_ack, c_mem_en && c_mem_we);
      if (c_mem_en && c_mem_we) begin
        check({pfx, " wr_addr"}, c_mem_addr, wr_addr);
        check({pfx, " wr_data"}, c_mem_wdata, wr_data);
        if (c <= r.exp_done) begin
          writes++;
          check({pfx, " wr_slot_pos"}, (c > 1) && ((c - 1) % 8 == 0), 1);
        end
      end
      if (c_wr_ack) begin
        if (c > r.exp_done && ack_after < 0) ack_after = c;
        wr_addr = wr_addr + 19'd1;
        wr_data = wr_data + 24'd1;
        if (c > r.exp_done) wr_req = 1'b0;
      end
      // line buffer gets the previous cycle's read, in x order without gaps
      check({pfx, " lb_we"}, c_lb_we, prev_rd);
      if (c_lb_we) begin
        check({pfx, " lb_addr"}, c_lb_addr, n_lb);
        check({pfx, " lb_wdata"}, c_lb_wdata, pix(prev_addr));
        n_lb++;
      end
      if (c_line_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c_req_err) begin
        err_cnt++;
        err_cyc = c;
      end
      check({pfx, " busy"}, c_busy, !r.exp_err && (c <= r.exp_done));
      prev_rd   = c_mem_en && !c_mem_we;
      prev_addr = c_mem_addr;
    end
    wr_req   = 1'b0;
    line_req = 1'b0;
    check({pfx, " n_reads"}, n_rd, r.exp_err ? 0 : 640);
    check({pfx, " n_lb"}, n_lb, r.exp_err ? 0 : 640);
    check({pfx, " n_writes"}, writes, r.exp_writes);
    check({pfx, " done_cnt"}, done_cnt, r.exp_err ? 0 : 1);
    check({pfx, " done_cyc"}, done_cyc, r.exp_err ? -1 : r.exp_done);
    check({pfx, " err_cnt"}, err_cnt, (r.exp_err || r.intr_cyc != 0) ? 1 : 0);
    check({pfx, " err_cyc"}, err_cyc, r.exp_err ? 1 : (r.intr_cyc != 0 ? r.intr_cyc + 1 : -1));
    check({pfx, " idle_ack"}, ack_after, r.exp_ack);
    repeat (2) @(negedge clk);
  endtask

  // All outputs of both instances, for the reset checks
  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {wr_ack_a, mem_en_a, mem_we_a, lb_we_a, busy_a, line_done_a, req_err_a, 1'b0};
  assign ctl_b = {wr_ack_b, mem_en_b, mem_we_b, lb_we_b, busy_b, line_done_b, req_err_b, 1'b0};

  task automatic check_all_zero(input string name);
    check({name, " ctl_a"}, ctl_a, 0);
    check({name, " ctl_b"}, ctl_b, 0);
    check({name, " data_a"}, (mem_addr_a != 0) || (mem_wdata_a != 0) || (lb_addr_a != 0) || (lb_wdata_a != 0), 0);
    check({name, " data_b"}, (mem_addr_b != 0) || (mem_wdata_b != 0) || (lb_addr_b != 0) || (lb_wdata_b != 0), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    row_t rr;
    rows[0] = '{1'b0, 12'd2,    1'b0, 0,   1'b0, 19'd1280,   641, 0,  -1};
    rows[1] = '{1'b0, 12'd479,  1'b1, 0,   1'b0, 19'd306560, 732, 91, 733};
    rows[2] = '{1'b1, 12'd5,    1'b1, 0,   1'b0, 19'd3200,   641, 0,  642};
    rows[3] = '{1'b0, 12'd480,  1'b0, 0,   1'b1, 19'd0,      0,   0,  -1};
    rows[4] = '{1'b1, 12'd4095, 1'b0, 0,   1'b1, 19'd0,      0,   0,  -1};
    rows[5] = '{1'b0, 12'd1,    1'b0, 100, 1'b0, 19'd640,    641, 0,  -1};
    rows[6] = '{1'b1, 12'd0,    1'b0, 0,   1'b0, 19'd0,      641, 0,  -1};

    rst = 1'b1; sel = 1'b0; line_req = 1'b0; line_y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Writer in IDLE: ack one cycle after the request, then at most every 2 cycles
    sel = 1'b0; wr_req = 1'b1; wr_addr = 19'd12345; wr_data = 24'hABCDEF;
    @(negedge clk);
    check("idle_wr1 ack", wr_ack_a, 1);
    check("idle_wr1 en_we", {mem_en_a, mem_we_a}, 3);
    check("idle_wr1 addr", mem_addr_a, 12345);
    check("idle_wr1 data", mem_wdata_a, 24'hABCDEF);
    @(negedge clk);
    check("idle_wr2 ack", wr_ack_a, 0);
    check("idle_wr2 en", mem_en_a, 0);
    @(negedge clk);
    check("idle_wr3 ack", wr_ack_a, 1);
    check("idle_wr3 en", mem_en_a, 1);
    wr_req = 1'b0;
    @(negedge clk);
    check("idle_wr4 ack", wr_ack_a, 0);

    // Writer address beyond the frame buffer: acked but dropped
    wr_req = 1'b1; wr_addr = 19'd307200; wr_data = 24'h123456;
    @(negedge clk);
    check("oob_wr ack", wr_ack_a, 1);
    check("oob_wr en", mem_en_a, 0);
    check("oob_wr we", mem_we_a, 0);
    wr_req = 1'b0;
    @(negedge clk);
    check("oob_wr2 ack", wr_ack_a, 0);

    // Table of line fetches
    for (int i = 0; i < 7; i++) begin
      rr = rows[i];
      run_row(i, rr);
    end

    // Reset in cycle 300 of a fetch aborts the line
    sel = 1'b0; line_y = 12'd7; line_req = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      line_req = 1'b0;
      if (c == 300) begin
        check("pre_rst busy", busy_a, 1);
        check("pre_rst lb_we", lb_we_a, 1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check_all_zero("rst_fetch");
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_rst quiet", {lb_we_a, line_done_a, busy_a, mem_en_a}, 0);
    end
    rr = '{1'b0, 12'd7, 1'b0, 0, 1'b0, 19'd4480, 641, 0, -1};
    run_row(7, rr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
